// File: rtl/vec_weight_acc.sv
// Two-stage Hamming-weight accumulator: popcounts each sub-vector beat and sums
// SUB_VEC_NO beats into one weight per vector, with a stall-aware output register.
module vec_weight_acc #(
  parameter int BUS_WIDTH    = 128,
  parameter int VECTOR_WIDTH = 920,
  parameter int VEC_ID_WIDTH = 8,
  parameter int SUB_VEC_NO   = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH,
  parameter int WEIGHT_WIDTH = $clog2(SUB_VEC_NO * BUS_WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [BUS_WIDTH-1:0]    up_Vector,
  input  logic [VEC_ID_WIDTH-1:0] up_VecID,
  input  logic                    up_Valid,
  input  logic                    up_Last,
  output logic                    up_Ready,
  output logic [WEIGHT_WIDTH-1:0] dn_Weight,
  output logic [VEC_ID_WIDTH-1:0] dn_VecID,
  output logic                    dn_Valid,
  output logic                    dn_Last,
  input  logic                    dn_Ready,
  output logic                    err_IDMismatch
);

  localparam int COUNT_WIDTH = $clog2(BUS_WIDTH + 1);
  localparam int BEAT_WIDTH  = (SUB_VEC_NO > 1) ? $clog2(SUB_VEC_NO) : 1;
  localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(SUB_VEC_NO - 1);

  logic                    en;
  logic [COUNT_WIDTH-1:0]  beat_pop;

  logic                    s1_valid;
  logic [COUNT_WIDTH-1:0]  s1_count;
  logic [VEC_ID_WIDTH-1:0] s1_id;
  logic                    s1_last;

  logic [BEAT_WIDTH-1:0]   beat_cnt;
  logic [WEIGHT_WIDTH-1:0] acc;
  logic [VEC_ID_WIDTH-1:0] cap_id;
  logic                    cap_last;

  logic                    step;
  logic                    first_beat;
  logic                    final_beat;
  logic [WEIGHT_WIDTH-1:0] count_ext;
  logic [WEIGHT_WIDTH-1:0] sum;
  logic [VEC_ID_WIDTH-1:0] vec_id;
  logic                    vec_last;

  // The whole pipeline advances only when the output register can take a new result.
  assign en       = !(dn_Valid && !dn_Ready);
  assign up_Ready = en;

  always_comb begin
    beat_pop = '0;
    for (int i = 0; i < BUS_WIDTH; i++) begin
      beat_pop = beat_pop + COUNT_WIDTH'(up_Vector[i]);
    end
  end

  assign step       = en && s1_valid;
  assign first_beat = (beat_cnt == '0);
  assign final_beat = (beat_cnt == LAST_BEAT);
  assign count_ext  = WEIGHT_WIDTH'(s1_count);
  assign sum        = first_beat ? count_ext : acc + count_ext;
  assign vec_id     = first_beat ? s1_id : cap_id;
  assign vec_last   = s1_last | (!first_beat && cap_last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_count <= '0;
      s1_id    <= '0;
      s1_last  <= 1'b0;
    end else if (en) begin
      s1_valid <= up_Valid;
      s1_count <= beat_pop;
      s1_id    <= up_VecID;
      s1_last  <= up_Last;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt <= '0;
      acc      <= '0;
      cap_id   <= '0;
      cap_last <= 1'b0;
    end else if (step) begin
      acc      <= sum;
      cap_id   <= vec_id;
      cap_last <= vec_last;
      beat_cnt <= final_beat ? '0 : beat_cnt + BEAT_WIDTH'(1);
    end
  end

  // A result is held until taken; dn_Valid drops on handshake unless the next one lands.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dn_Valid  <= 1'b0;
      dn_Weight <= '0;
      dn_VecID  <= '0;
      dn_Last   <= 1'b0;
    end else if (en) begin
      dn_Valid <= step && final_beat;
      if (step && final_beat) begin
        dn_Weight <= sum;
        dn_VecID  <= vec_id;
        dn_Last   <= vec_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_IDMismatch <= 1'b0;
    end else if (step && !first_beat && (s1_id != cap_id)) begin
      err_IDMismatch <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vec_weight_acc.sv
// Self-checking bench for vec_weight_acc: directed scenarios plus randomized traffic
// compared every cycle against a beat-list model of vector weights.
module tb_vec_weight_acc;

  localparam int BW  = 128;
  localparam int IDW = 8;
  localparam int NB  = 8;
  localparam int WW  = 11;

  logic           clk = 1'b0;
  logic           rstn;
  logic [BW-1:0]  up_Vector;
  logic [IDW-1:0] up_VecID;
  logic           up_Valid;
  logic           up_Last;
  logic           up_Ready;
  logic [WW-1:0]  dn_Weight;
  logic [IDW-1:0] dn_VecID;
  logic           dn_Valid;
  logic           dn_Last;
  logic           dn_Ready = 1'b1;
  logic           err_IDMismatch;

  vec_weight_acc #(
    .BUS_WIDTH(BW),
    .VECTOR_WIDTH(920),
    .VEC_ID_WIDTH(IDW)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .up_Vector(up_Vector),
    .up_VecID(up_VecID),
    .up_Valid(up_Valid),
    .up_Last(up_Last),
    .up_Ready(up_Ready),
    .dn_Weight(dn_Weight),
    .dn_VecID(dn_VecID),
    .dn_Valid(dn_Valid),
    .dn_Last(dn_Last),
    .dn_Ready(dn_Ready),
    .err_IDMismatch(err_IDMismatch)
  );

  always #5 clk = ~clk;

  typedef struct {
    int weight;
    int id;
    bit last;
    bit mism;
    int fin;
  } exp_t;

  typedef struct {
    int weight;
    int id;
    bit last;
    bit err;
    int cyc;
  } seen_t;

  exp_t  exp_q[$];
  seen_t seen_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit ready_hist [0:49999];
  int ready_mode = 0;
  int stall_left = 0;
  int stall_cycles = 0;

  int m_beats = 0;
  int m_sum = 0;
  int m_id = 0;
  bit m_last = 1'b0;
  bit m_mism = 1'b0;
  bit mism_any = 1'b0;
  bit err_must = 1'b0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // dn_Ready policy: always ready, random back-pressure, or a fixed stall on a pending result.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: dn_Ready = 1'b1;
      1: dn_Ready = ($urandom_range(0, 99) < 70);
      default: begin
        if (dn_Valid && stall_left > 0) begin
          dn_Ready = 1'b0;
          stall_left--;
        end else begin
          dn_Ready = 1'b1;
        end
      end
    endcase
  end

  // Reference model: group accepted beats into vectors and compare each presented result.
  always @(negedge clk) begin
    if (cyc < 50000) ready_hist[cyc] = dn_Ready;
    if (!rstn) begin
      exp_q.delete();
      m_beats  = 0;
      mism_any = 1'b0;
      err_must = 1'b0;
      check_output("reset dn_Valid", dn_Valid, 0);
      check_output("reset err", err_IDMismatch, 0);
      check_output("reset up_Ready", up_Ready, 1);
    end else begin
      check_output("up_Ready rule", up_Ready, !(dn_Valid && !dn_Ready));
      if (!up_Ready) stall_cycles++;
      if (exp_q.size() > 0 && cyc == exp_q[0].fin + 2 && exp_q[0].fin + 1 < 50000
          && ready_hist[exp_q[0].fin + 1]) begin
        check_output("latency dn_Valid", dn_Valid, 1);
      end
      if (dn_Valid) begin
        if (exp_q.size() == 0) begin
          check_output("spurious dn_Valid", dn_Valid, 0);
        end else begin
          check_output("dn_Weight", dn_Weight, exp_q[0].weight);
          check_output("dn_VecID", dn_VecID, exp_q[0].id);
          check_output("dn_Last", dn_Last, exp_q[0].last);
          if (exp_q[0].mism) err_must = 1'b1;
          if (dn_Ready) begin
            seen_q.push_back('{int'(dn_Weight), int'(dn_VecID), dn_Last, err_IDMismatch, cyc});
            void'(exp_q.pop_front());
          end
        end
      end
      if (!mism_any) check_output("err clear", err_IDMismatch, 0);
      if (err_must) check_output("err sticky", err_IDMismatch, 1);
      if (up_Valid && up_Ready) begin
        if (m_beats == 0) begin
          m_sum  = 0;
          m_id   = int'(up_VecID);
          m_last = 1'b0;
          m_mism = 1'b0;
        end else if (int'(up_VecID) != m_id) begin
          m_mism   = 1'b1;
          mism_any = 1'b1;
        end
        m_sum  += $countones(up_Vector);
        m_last |= up_Last;
        m_beats++;
        if (m_beats == NB) begin
          exp_q.push_back('{m_sum, m_id, m_last, m_mism, cyc});
          m_beats = 0;
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [BW-1:0] vec, input logic [IDW-1:0] id, input logic last);
    int n = 0;
    @(posedge clk);
    #1;
    up_Vector = vec;
    up_VecID  = id;
    up_Last   = last;
    up_Valid  = 1'b1;
    @(negedge clk);
    while (!up_Ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check_output("beat accept timeout", n, 0);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    up_Valid  = 1'b0;
    up_Vector = {$urandom, $urandom, $urandom, $urandom};
    up_VecID  = IDW'($urandom);
    up_Last   = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    ready_mode = 0;
    @(negedge clk);
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("drain timeout", (n < 200), 1);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [BW-1:0] rand_vec();
    logic [BW-1:0] v;
    case ($urandom_range(0, 3))
      0: v = '0;
      1: v = '1;
      default: v = {$urandom, $urandom, $urandom, $urandom};
    endcase
    return v;
  endfunction

  // Directed scenarios first (each pins literal results), then randomized traffic.
  initial begin
    logic [BW-1:0] v;
    int c;
    rstn = 1'b0;
    up_Valid = 1'b0;
    up_Vector = '0;
    up_VecID = '0;
    up_Last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("init dn_Weight", dn_Weight, 0);
    check_output("init dn_VecID", dn_VecID, 0);
    check_output("init up_Ready", up_Ready, 1);
    rstn = 1'b1;

    // Full-weight vector of 920 ones
    seen_q.delete();
    for (int b = 0; b < NB - 1; b++) apply_stimulus('1, 8'd3, 1'b0);
    v = {{24{1'b1}}, {104{1'b0}}};
    apply_stimulus(v, 8'd3, 1'b0);
    c = cyc;
    idle();
    drain();
    check_output("t035 count", seen_q.size(), 1);
    if (seen_q.size() >= 1) begin
      check_output("t035 weight", seen_q[0].weight, 920);
      check_output("t035 id", seen_q[0].id, 3);
      check_output("t035 latency", seen_q[0].cyc, c + 2);
    end

    // Back-to-back weights 0 then 8
    seen_q.delete();
    for (int b = 0; b < NB; b++) apply_stimulus('0, 8'd0, 1'b0);
    for (int b = 0; b < NB; b++) begin
      v = '0;
      v[b * 13] = 1'b1;
      apply_stimulus(v, 8'd1, 1'b0);
    end
    idle();
    drain();
    check_output("t036 count", seen_q.size(), 2);
    if (seen_q.size() >= 2) begin
      check_output("t036 weight0", seen_q[0].weight, 0);
      check_output("t036 weight1", seen_q[1].weight, 8);
      check_output("t036 id1", seen_q[1].id, 1);
      check_output("t036 spacing", seen_q[1].cyc - seen_q[0].cyc, NB);
    end

    // Five-cycle output stall while the next vector streams
    seen_q.delete();
    for (int b = 0; b < NB; b++) apply_stimulus(128'hFF << b, 8'd7, 1'b0);
    stall_left = 5;
    stall_cycles = 0;
    ready_mode = 2;
    for (int b = 0; b < NB; b++) apply_stimulus(128'hFFFF << (b * 3), 8'd8, 1'b0);
    idle();
    drain();
    check_output("t037 stall cycles", stall_cycles, 5);
    check_output("t037 count", seen_q.size(), 2);
    if (seen_q.size() >= 2) begin
      check_output("t037 weight0", seen_q[0].weight, 64);
      check_output("t037 weight1", seen_q[1].weight, 128);
      check_output("t037 id1", seen_q[1].id, 8);
    end

    // Last flag only on beat 7, then a vector without Last
    seen_q.delete();
    for (int b = 0; b < NB; b++) apply_stimulus(rand_vec(), 8'd10, (b == NB - 1));
    for (int b = 0; b < NB; b++) apply_stimulus(rand_vec(), 8'd11, 1'b0);
    idle();
    drain();
    check_output("t038 count", seen_q.size(), 2);
    if (seen_q.size() >= 2) begin
      check_output("t038 last0", seen_q[0].last, 1);
      check_output("t038 last1", seen_q[1].last, 0);
    end

    // ID mismatch on beat 3 is flagged and sticky
    seen_q.delete();
    for (int b = 0; b < NB; b++) begin
      v = '0;
      v[b * 7 + 2] = 1'b1;
      apply_stimulus(v, (b == 3) ? 8'd5 : 8'd4, 1'b0);
    end
    for (int b = 0; b < NB; b++) apply_stimulus(128'h3 << (b * 9), 8'd9, 1'b0);
    idle();
    drain();
    check_output("t040 count", seen_q.size(), 2);
    if (seen_q.size() >= 2) begin
      check_output("t040 weight", seen_q[0].weight, 8);
      check_output("t040 id", seen_q[0].id, 4);
      check_output("t040 err", seen_q[0].err, 1);
      check_output("t040 err next", seen_q[1].err, 1);
    end
    check_output("t040 err held", err_IDMismatch, 1);

    // Reset mid-vector, then a fresh all-ones vector
    seen_q.delete();
    for (int b = 0; b < 5; b++) apply_stimulus('1, 8'd2, 1'b0);
    @(posedge clk);
    #1;
    up_Valid = 1'b0;
    #1;
    rstn = 1'b0;
    #1;
    check_output("t039 dn_Valid", dn_Valid, 0);
    check_output("t039 dn_Weight", dn_Weight, 0);
    check_output("t039 dn_VecID", dn_VecID, 0);
    check_output("t039 dn_Last", dn_Last, 0);
    check_output("t039 err", err_IDMismatch, 0);
    check_output("t039 up_Ready", up_Ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int b = 0; b < NB; b++) apply_stimulus('1, 8'd6, 1'b0);
    idle();
    drain();
    check_output("t039 count", seen_q.size(), 1);
    if (seen_q.size() >= 1) begin
      check_output("t039 weight", seen_q[0].weight, 1024);
      check_output("t039 id", seen_q[0].id, 6);
    end

    // Randomized traffic with bubbles and back-pressure
    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      logic [IDW-1:0] id;
      id = IDW'($urandom);
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 99) < 30) begin
          for (int k = 0; k < int'($urandom_range(1, 3)); k++) idle();
        end
        apply_stimulus(rand_vec(), id, ($urandom_range(0, 9) == 0));
      end
    end
    idle();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
